// File: rtl/line_drawer_pkg.sv
// line_drawer_pkg
//   Shared types and defaults for the Bresenham line rasteriser.
//   state_t  : controller states (CLEAR only reachable with CLEAR_LINE_DRAWER_EN)
//   coord_t  : 11-bit unsigned screen coordinate
//   err_t    : 12-bit signed Bresenham error / delta
//   abs_diff : |a-b| for unsigned coordinates
package line_drawer_pkg;

  localparam int unsigned H_PIXELS_DEF = 640;
  localparam int unsigned V_PIXELS_DEF = 480;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    DRAW,
    DONE,
    CLEAR
  } state_t;

  typedef logic [10:0]        coord_t;
  typedef logic signed [11:0] err_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/line_drawer.sv
// line_drawer
//   Bresenham line rasteriser feeding the 640x480 1-bpp framebuffer write port.
//   One pixel write per clock; pixels outside the visible area are suppressed
//   but still consume a DRAW cycle.
//   Optional feature: define CLEAR_LINE_DRAWER_EN to build the full-screen
//   clear (raster sweep writing colour 0 to every visible pixel).
// Ports
//   clk50        : clock
//   reset_n      : synchronous active-low reset
//   start        : line request, sampled only in IDLE
//   x0,y0,x1,y1  : endpoints, latched on accepted start
//   color        : pixel colour, latched on accepted start
//   clear        : full-screen clear request (ignored unless CLEAR_LINE_DRAWER_EN)
//   x,y          : pixel coordinate to framebuffer
//   pixel_color  : pixel value to framebuffer
//   pixel_write  : write strobe
//   busy         : high from the cycle after acceptance until done
//   done         : one-cycle completion pulse
module line_drawer
  import line_drawer_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_PIXELS = V_PIXELS_DEF
) (
  input  logic         clk50,
  input  logic         reset_n,
  input  logic         start,
  input  logic [10:0]  x0,
  input  logic [10:0]  y0,
  input  logic [10:0]  x1,
  input  logic [10:0]  y1,
  input  logic         color,
  input  logic         clear,
  output logic [10:0]  x,
  output logic [10:0]  y,
  output logic         pixel_color,
  output logic         pixel_write,
  output logic         busy,
  output logic         done
);

  localparam coord_t H_LIM = coord_t'(H_PIXELS);
  localparam coord_t V_LIM = coord_t'(V_PIXELS);

  state_t state;

  // Endpoints and colour captured at acceptance
  coord_t lx0, ly0, lx1, ly1;
  logic   lcolor;

  // Walk state: major axis steps every cycle, minor axis on error overflow
  coord_t major, minor, remaining;
  err_t   err, dx, dy;
  logic   steep, ystep_neg;

  // SETUP arithmetic (octant normalisation)
  logic   s_steep;
  coord_t a0, b0, a1, b1;
  coord_t sa0, sb0, sa1, sb1;
  err_t   s_dx, s_dy, s_err;

  always_comb begin
    s_steep = abs_diff(ly0, ly1) > abs_diff(lx0, lx1);
    a0 = s_steep ? ly0 : lx0;
    b0 = s_steep ? lx0 : ly0;
    a1 = s_steep ? ly1 : lx1;
    b1 = s_steep ? lx1 : ly1;
    // Always walk from the lower major-axis end
    if (a0 > a1) begin
      sa0 = a1; sb0 = b1;
      sa1 = a0; sb1 = b0;
    end else begin
      sa0 = a0; sb0 = b0;
      sa1 = a1; sb1 = b1;
    end
    s_dx  = err_t'({1'b0, sa1 - sa0});
    s_dy  = err_t'({1'b0, abs_diff(sb0, sb1)});
    s_err = -(s_dx >>> 1);
  end

  // DRAW arithmetic
  err_t   err_sum;
  coord_t out_x, out_y;
  logic   clipped;

  always_comb begin
    err_sum = err + dy;
    out_x   = steep ? minor : major;
    out_y   = steep ? major : minor;
    clipped = (out_x >= H_LIM) || (out_y >= V_LIM);
  end

`ifndef CLEAR_LINE_DRAWER_EN
  logic unused_clear;
  assign unused_clear = clear;
`endif

  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pixel_color <= 1'b0;
      pixel_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lx0         <= '0;
      ly0         <= '0;
      lx1         <= '0;
      ly1         <= '0;
      lcolor      <= 1'b0;
      major       <= '0;
      minor       <= '0;
      remaining   <= '0;
      err         <= '0;
      dx          <= '0;
      dy          <= '0;
      steep       <= 1'b0;
      ystep_neg   <= 1'b0;
    end else begin
      pixel_write <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          // done is visible while already back in IDLE; requests in that
          // cycle are dropped rather than starting a new line.
`ifdef CLEAR_LINE_DRAWER_EN
          if (clear && !done) begin
            state <= CLEAR;
            busy  <= 1'b1;
            major <= '0;
            minor <= '0;
          end else
`endif
          if (start && !done) begin
            lx0    <= x0;
            ly0    <= y0;
            lx1    <= x1;
            ly1    <= y1;
            lcolor <= color;
            busy   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          steep     <= s_steep;
          major     <= sa0;
          minor     <= sb0;
          remaining <= sa1 - sa0;
          dx        <= s_dx;
          dy        <= s_dy;
          err       <= s_err;
          ystep_neg <= sb1 < sb0;
          state     <= DRAW;
        end

        DRAW: begin
          x           <= out_x;
          y           <= out_y;
          pixel_color <= lcolor;
          pixel_write <= !clipped;
          if (!err_sum[11]) begin
            minor <= ystep_neg ? (minor - 1'b1) : (minor + 1'b1);
            err   <= err_sum - dx;
          end else begin
            err   <= err_sum;
          end
          major <= major + 1'b1;
          if (remaining == '0) begin
            state <= DONE;
          end else begin
            remaining <= remaining - 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end

`ifdef CLEAR_LINE_DRAWER_EN
        CLEAR: begin
          // major/minor double as the raster column/row counters
          x           <= major;
          y           <= minor;
          pixel_color <= 1'b0;
          pixel_write <= 1'b1;
          if (major == H_LIM - 1'b1) begin
            major <= '0;
            if (minor == V_LIM - 1'b1) begin
              state <= DONE;
            end else begin
              minor <= minor + 1'b1;
            end
          end else begin
            major <= major + 1'b1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer
//   Scoreboard bench for line_drawer: stimulus pushes the reference pixel list
//   and per-line write count; a negedge monitor pops and compares every write
//   and every done pulse.
module tb_line_drawer;
  import line_drawer_pkg::*;

  localparam int H = 640;
  localparam int V = 480;

  logic   clk50 = 1'b0;
  logic   reset_n = 1'b0;
  logic   start = 1'b0;
  logic   color = 1'b0;
  logic   clear = 1'b0;
  coord_t x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  coord_t x, y;
  logic   pixel_color, pixel_write, busy, done;

  line_drawer #(.H_PIXELS(640), .V_PIXELS(480)) dut (
    .clk50(clk50), .reset_n(reset_n), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color), .clear(clear),
    .x(x), .y(y), .pixel_color(pixel_color), .pixel_write(pixel_write),
    .busy(busy), .done(done)
  );

  always #10 clk50 = ~clk50;

  typedef struct { int px; int py; int c; } pix_t;
  pix_t exp_q[$];
  int   cnt_q[$];
  int   checks = 0;
  int   failures = 0;
  int   line_writes = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  // Reference rasteriser: integer Bresenham from the lower major-axis end,
  // dropping off-screen pixels.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int c, output int len);
    int   a0, b0, a1, b1, t, ddx, ddy, err, b, step, px, py;
    int   cnt;
    bit   stp;
    pix_t p;
    cnt = 0;
    stp = iabs(ay1 - ay0) > iabs(ax1 - ax0);
    if (stp) begin a0 = ay0; b0 = ax0; a1 = ay1; b1 = ax1; end
    else     begin a0 = ax0; b0 = ay0; a1 = ax1; b1 = ay1; end
    if (a0 > a1) begin
      t = a0; a0 = a1; a1 = t;
      t = b0; b0 = b1; b1 = t;
    end
    ddx  = a1 - a0;
    ddy  = iabs(b1 - b0);
    step = (b1 >= b0) ? 1 : -1;
    err  = -(ddx / 2);
    b    = b0;
    for (int a = a0; a <= a1; a++) begin
      px = stp ? b : a;
      py = stp ? a : b;
      if (px < H && py < V) begin
        p.px = px; p.py = py; p.c = c;
        exp_q.push_back(p);
        cnt++;
      end
      err += ddy;
      if (err >= 0) begin
        b   += step;
        err -= ddx;
      end
    end
    cnt_q.push_back(cnt);
    len = ddx;
  endtask

  // Monitor / scoreboard
  always @(negedge clk50) begin
    pix_t e;
    int   n;
    if (reset_n) begin
      if (pixel_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got=(%0d,%0d,%0d) exp=none", x, y, pixel_color);
        end else begin
          e = exp_q.pop_front();
          if (x !== e.px || y !== e.py || pixel_color !== e.c[0]) begin
            failures++;
            $display("FAIL pixel got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                     x, y, pixel_color, e.px, e.py, e.c);
          end
        end
        line_writes++;
      end
      if (done) begin
        checks++;
        if (cnt_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done got=1 exp=0");
        end else begin
          n = cnt_q.pop_front();
          if (line_writes != n) begin
            failures++;
            $display("FAIL write_count got=%0d exp=%0d", line_writes, n);
          end
        end
        line_writes = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || done) && t < 5000) begin tick(); t++; end
    if (busy || done) chk("idle_timeout", 1, 0);
  endtask

  // Issue one line; count busy cycles; optionally poke ignored starts.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int c, input bit poke, input bit lat);
    int len, bcyc, t;
    wait_idle();
    x0 = coord_t'(ax0); y0 = coord_t'(ay0);
    x1 = coord_t'(ax1); y1 = coord_t'(ay1);
    color = c[0];
    start = 1'b1;
    model_line(ax0, ay0, ax1, ay1, c, len);
    tick();
    start = 1'b0;
    bcyc = 0;
    t = 0;
    while (!done && t < 5000) begin
      if (busy) bcyc++;
      if (lat && t == 1) chk("lat_no_write_yet", int'(pixel_write), 0);
      if (lat && t == 2) chk("lat_first_write", int'(pixel_write), 1);
      if (poke && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        x0 = coord_t'($urandom_range(0, 60)); y0 = coord_t'($urandom_range(0, 60));
        x1 = coord_t'($urandom_range(0, 60)); y1 = coord_t'($urandom_range(0, 60));
        color = ~color;
      end else begin
        start = 1'b0;
      end
      tick();
      t++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    chk("busy_cycles", bcyc, len + 3);
    chk("busy_low_at_done", int'(busy), 0);
    if (poke) begin
      // request on the done cycle must be dropped
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_on_done_ignored", int'(busy), 0);
    end
  endtask

  function automatic int rnd_coord(input bit edge_zone, input bit is_y);
    if (!edge_zone) return $urandom_range(0, 40);
    return is_y ? $urandom_range(455, 505) : $urandom_range(615, 665);
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_pixel_color"}, int'(pixel_color), 0);
    chk({tag, "_pixel_write"}, int'(pixel_write), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int k, t, len;
    bit ez;
    reset_n = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    tick();

    // Directed cases
    run_line(0, 0, 3, 0, 1, 1'b0, 1'b1);
    run_line(2, 5, 0, 0, 1, 1'b0, 1'b0);
    run_line(7, 7, 7, 7, 1, 1'b0, 1'b0);
    run_line(638, 479, 641, 479, 1, 1'b0, 1'b0);
    run_line(0, 0, 9, 9, 1, 1'b1, 1'b0);

    // clear must have no effect in the default build
`ifndef CLEAR_LINE_DRAWER_EN
    wait_idle();
    clear = 1'b1;
    repeat (4) begin
      tick();
      chk("clear_ignored_busy", int'(busy), 0);
    end
    clear = 1'b0;
`endif

    // Randomised lines, some straddling the right/bottom edges
    for (int i = 0; i < 40; i++) begin
      ez = ($urandom_range(0, 3) == 0);
      run_line(rnd_coord(ez, 1'b0), rnd_coord(ez, 1'b1),
               rnd_coord(ez, 1'b0), rnd_coord(ez, 1'b1),
               $urandom_range(0, 1), bit'($urandom_range(0, 1)), 1'b0);
    end

    // Reset mid-line at the 5th write
    wait_idle();
    x0 = '0; y0 = '0; x1 = 11'd9; y1 = 11'd9; color = 1'b1;
    start = 1'b1;
    model_line(0, 0, 9, 9, 1, len);
    tick();
    start = 1'b0;
    k = 0;
    t = 0;
    while (k < 5 && t < 100) begin
      if (pixel_write) k++;
      if (k < 5) begin tick(); t++; end
    end
    chk("fifth_write_reached", k, 5);
    reset_n = 1'b0;
    tick();
    chk_outputs_zero("midline_reset");
    exp_q.delete();
    cnt_q.delete();
    line_writes = 0;
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      chk("after_reset_no_write", int'(pixel_write), 0);
    end
    run_line(5, 3, 1, 12, 0, 1'b0, 1'b0);

`ifdef CLEAR_LINE_DRAWER_EN
    begin
      pix_t p;
      int bc;
      wait_idle();
      for (int yy = 0; yy < V; yy++)
        for (int xx = 0; xx < H; xx++) begin
          p.px = xx; p.py = yy; p.c = 0;
          exp_q.push_back(p);
        end
      cnt_q.push_back(H * V);
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      bc = 0;
      t = 0;
      while (!done && t < 320000) begin
        if (busy) bc++;
        tick();
        t++;
      end
      if (!done) chk("clear_timeout", 0, 1);
      chk("clear_busy_cycles", bc, H * V + 1);
    end
`endif

    repeat (4) tick();
    chk("scoreboard_pixels_left", exp_q.size(), 0);
    chk("scoreboard_lines_left", cnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
